// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_pkg
//  Description : Shared types for the 5-stage pipeline sequencer. Holds the
//                controller state encoding and the per-stage rst/en bundle
//                layout used by pipeline_ctrl.
//  Contents    : ctrl_state_e  - INIT/RUN/HALT/STEP state encoding
//                stage_ctrl_t  - {rst[4:0], en[4:0]}, bit 4 = IF ... bit 0 = WB
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } ctrl_state_e;

    // Stage order inside each 5-bit field: [4]=IF [3]=ID [2]=EXE [1]=MEM [0]=WB
    typedef struct packed {
        logic [4:0] rst;
        logic [4:0] en;
    } stage_ctrl_t;

    localparam stage_ctrl_t C_CTRL_INIT   = '{rst: 5'b11111, en: 5'b00000};
    localparam stage_ctrl_t C_CTRL_FREEZE = '{rst: 5'b00000, en: 5'b00000};
    // Flush: IF loads the branch target, ID/EXE/MEM are cleared, WB retires
    // the branch itself.
    localparam stage_ctrl_t C_CTRL_FLUSH  = '{rst: 5'b01110, en: 5'b10001};
    // Bubble: IF/ID hold, EXE receives a NOP, MEM/WB keep draining.
    localparam stage_ctrl_t C_CTRL_BUBBLE = '{rst: 5'b00100, en: 5'b00011};
    localparam stage_ctrl_t C_CTRL_RUN    = '{rst: 5'b00000, en: 5'b11111};

    // True when the state is one in which the pipeline may move forward.
    function automatic logic is_adv_state(input ctrl_state_e st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_event_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_event_cnt
//  Description : Free-running event counter with synchronous active-low clear.
//                Wraps modulo 2^CNT_W, no saturation.
//  Ports       : clk   - clock
//                rst_n - synchronous active-low clear
//                inc   - count enable, one increment per cycle
//                count - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_event_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule : pipe_event_cnt
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Stage sequencer for the 5-stage MIPS pipeline. Produces the
//                per-stage rst/en pairs, handling power-up hold, load-use
//                bubbles, taken-branch flush, memory-busy freeze and a debug
//                run/halt/single-step mode. Keeps cycle/stall/flush counters.
//  Ports       : clk, rst_n           - clock, synchronous active-low reset
//                step_mode, step_req  - debug halt mode / single-step pulse
//                mem_busy             - freeze whole pipeline
//                reg_stall, id_valid  - load-use hazard in ID
//                is_branch_mem        - taken branch resolved in MEM
//                *_rst, *_en          - per-stage reset/enable to datapath
//                halted, ctrl_state   - status
//                cycle/stall/flush_cnt- event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             mem_busy,
    input  logic             reg_stall,
    input  logic             id_valid,
    input  logic             is_branch_mem,
    output logic             if_rst,
    output logic             id_rst,
    output logic             exe_rst,
    output logic             mem_rst,
    output logic             wb_rst,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             halted,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] C_INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    ctrl_state_e       state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;

    stage_ctrl_t       ctrl;
    logic              advance;
    logic              do_flush;
    logic              do_bubble;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            ST_INIT: begin
                if (init_cnt_q == C_INIT_LAST) begin
                    state_d = step_mode ? ST_HALT : ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            ST_RUN: begin
                if (step_mode) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                // Leaving debug mode wins over a coincident step request.
                if (!step_mode) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                // A step is only consumed by a cycle that actually advances.
                if (!mem_busy) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage control. A branch flush outranks a load-use bubble because the
    // stalled instruction is on the wrong path. While frozen the hazard
    // sources stay captured in the datapath registers and are serviced
    // on the first non-busy cycle.
    // ------------------------------------------------------------------
    assign advance   = is_adv_state(state_q) && !mem_busy;
    assign do_flush  = advance && is_branch_mem;
    assign do_bubble = advance && !is_branch_mem && reg_stall && id_valid;

    always_comb begin
        ctrl = C_CTRL_FREEZE;
        if (state_q == ST_INIT) begin
            ctrl = C_CTRL_INIT;
        end else if (!advance) begin
            ctrl = C_CTRL_FREEZE;
        end else if (do_flush) begin
            ctrl = C_CTRL_FLUSH;
        end else if (do_bubble) begin
            ctrl = C_CTRL_BUBBLE;
        end else begin
            ctrl = C_CTRL_RUN;
        end
    end

    assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = ctrl.rst;
    assign {if_en,  id_en,  exe_en,  mem_en,  wb_en } = ctrl.en;

    assign halted     = (state_q == ST_HALT);
    assign ctrl_state = state_q;

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
    pipe_event_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (advance),
        .count (cycle_cnt)
    );

    pipe_event_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_bubble),
        .count (stall_cnt)
    );

    pipe_event_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_flush),
        .count (flush_cnt)
    );

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Self-checking bench for pipeline_ctrl. A behavioural model
//                tracks the controller mode and event counts; a compare
//                process checks every DUT output each cycle. Directed
//                scenarios with literal expectations come first, followed
//                by randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int INIT_CYCLES = 4;
    localparam int CNT_W       = 4;
    localparam int MOD         = 1 << CNT_W;

    localparam logic [9:0] V_INIT   = 10'b11111_00000;
    localparam logic [9:0] V_FREEZE = 10'b00000_00000;
    localparam logic [9:0] V_FLUSH  = 10'b01110_10001;
    localparam logic [9:0] V_BUBBLE = 10'b00100_00011;
    localparam logic [9:0] V_RUN    = 10'b00000_11111;

    logic clk = 1'b0;
    logic rst_n, step_mode, step_req, mem_busy, reg_stall, id_valid, is_branch_mem;
    logic if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic if_en, id_en, exe_en, mem_en, wb_en;
    logic halted;
    logic [1:0] ctrl_state;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
    logic [9:0] dut_vec;

    int nerr = 0;
    int nchk = 0;

    pipeline_ctrl #(.INIT_CYCLES(INIT_CYCLES), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .step_mode     (step_mode),
        .step_req      (step_req),
        .mem_busy      (mem_busy),
        .reg_stall     (reg_stall),
        .id_valid      (id_valid),
        .is_branch_mem (is_branch_mem),
        .if_rst        (if_rst),
        .id_rst        (id_rst),
        .exe_rst       (exe_rst),
        .mem_rst       (mem_rst),
        .wb_rst        (wb_rst),
        .if_en         (if_en),
        .id_en         (id_en),
        .exe_en        (exe_en),
        .mem_en        (mem_en),
        .wb_en         (wb_en),
        .halted        (halted),
        .ctrl_state    (ctrl_state),
        .cycle_cnt     (cycle_cnt),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    assign dut_vec = {if_rst, id_rst, exe_rst, mem_rst, wb_rst,
                      if_en, id_en, exe_en, mem_en, wb_en};

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: mode 0=INIT 1=RUN 2=HALT 3=STEP
    // ------------------------------------------------------------------
    int m_mode  = 0;
    int m_init  = 0;
    int m_cyc   = 0;
    int m_stall = 0;
    int m_flush = 0;
    bit armed   = 1'b0;

    function automatic logic [9:0] exp_vec(input int mode, input bit busy,
                                           input bit br, input bit rs, input bit iv);
        if (mode == 0) return V_INIT;
        if (!(mode == 1 || mode == 3) || busy) return V_FREEZE;
        if (br) return V_FLUSH;
        if (rs && iv) return V_BUBBLE;
        return V_RUN;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode  = 0;
            m_init  = 0;
            m_cyc   = 0;
            m_stall = 0;
            m_flush = 0;
            armed   = 1'b1;
        end else if (armed) begin
            if ((m_mode == 1 || m_mode == 3) && !mem_busy) begin
                m_cyc = (m_cyc + 1) % MOD;
                if (is_branch_mem)
                    m_flush = (m_flush + 1) % MOD;
                else if (reg_stall && id_valid)
                    m_stall = (m_stall + 1) % MOD;
            end
            case (m_mode)
                0: begin
                    m_init = m_init + 1;
                    if (m_init >= INIT_CYCLES) m_mode = step_mode ? 2 : 1;
                end
                1: if (step_mode) m_mode = 2;
                2: begin
                    if (!step_mode) m_mode = 1;
                    else if (step_req) m_mode = 3;
                end
                default: if (!mem_busy) m_mode = 2;
            endcase
        end
    end

    // Compare process: all outputs, every cycle, against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("stage_vec", int'(dut_vec),
                int'(exp_vec(m_mode, mem_busy, is_branch_mem, reg_stall, id_valid)));
            chk("halted", int'(halted), (m_mode == 2) ? 1 : 0);
            chk("ctrl_state", int'(ctrl_state), m_mode);
            chk("cycle_cnt", int'(cycle_cnt), m_cyc);
            chk("stall_cnt", int'(stall_cnt), m_stall);
            chk("flush_cnt", int'(flush_cnt), m_flush);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with literal expectations, then random traffic
    // ------------------------------------------------------------------
    initial begin : main
        int n;
        rst_n = 1'b0; step_mode = 1'b0; step_req = 1'b0; mem_busy = 1'b0;
        reg_stall = 1'b0; id_valid = 1'b0; is_branch_mem = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Power-up hold length
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!if_rst) break;
            n++;
            tick();
        end
        chk("lit_init_len", n, INIT_CYCLES);
        chk("lit_run_vec", int'(dut_vec), int'(V_RUN));
        chk("lit_run_state", int'(ctrl_state), 1);
        tick();

        // Load-use bubble
        reg_stall = 1'b1; id_valid = 1'b1;
        @(negedge clk); chk("lit_bubble_vec", int'(dut_vec), int'(V_BUBBLE)); tick();
        reg_stall = 1'b0;
        @(negedge clk); chk("lit_stall_cnt1", int'(stall_cnt), 1); tick();
        reg_stall = 1'b1; id_valid = 1'b0;
        @(negedge clk); chk("lit_noval_vec", int'(dut_vec), int'(V_RUN)); tick();
        reg_stall = 1'b0;
        @(negedge clk); chk("lit_stall_cnt_hold", int'(stall_cnt), 1); tick();

        // Flush beats a coincident stall
        is_branch_mem = 1'b1; reg_stall = 1'b1; id_valid = 1'b1;
        @(negedge clk); chk("lit_flush_vec", int'(dut_vec), int'(V_FLUSH)); tick();
        is_branch_mem = 1'b0; reg_stall = 1'b0;
        @(negedge clk);
        chk("lit_flush_cnt1", int'(flush_cnt), 1);
        chk("lit_stall_after_flush", int'(stall_cnt), 1);
        tick();

        // Memory-busy freeze with pending branch
        mem_busy = 1'b1; is_branch_mem = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lit_busy_vec", int'(dut_vec), int'(V_FREEZE));
            chk("lit_busy_cycle", int'(cycle_cnt), 7);
            tick();
        end
        mem_busy = 1'b0;
        @(negedge clk); chk("lit_late_flush_vec", int'(dut_vec), int'(V_FLUSH)); tick();
        is_branch_mem = 1'b0;
        @(negedge clk);
        chk("lit_flush_cnt2", int'(flush_cnt), 2);
        chk("lit_cycle8", int'(cycle_cnt), 8);
        tick();

        // Halt and single step
        step_mode = 1'b1;
        @(negedge clk); tick();
        @(negedge clk);
        chk("lit_halt_state", int'(ctrl_state), 2);
        chk("lit_halted", int'(halted), 1);
        chk("lit_halt_vec", int'(dut_vec), int'(V_FREEZE));
        tick();
        step_req = 1'b1;
        @(negedge clk); tick();
        step_req = 1'b0;
        @(negedge clk);
        chk("lit_step_state", int'(ctrl_state), 3);
        chk("lit_step_vec", int'(dut_vec), int'(V_RUN));
        tick();
        @(negedge clk);
        chk("lit_back_halt", int'(ctrl_state), 2);
        chk("lit_step_cycle", int'(cycle_cnt), 11);
        tick();

        // Step delayed by memory busy
        step_req = 1'b1; mem_busy = 1'b1;
        @(negedge clk); tick();
        step_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("lit_step_busy_state", int'(ctrl_state), 3);
            chk("lit_step_busy_vec", int'(dut_vec), int'(V_FREEZE));
            tick();
        end
        mem_busy = 1'b0;
        @(negedge clk); chk("lit_step_late_vec", int'(dut_vec), int'(V_RUN)); tick();
        @(negedge clk); chk("lit_step_late_cycle", int'(cycle_cnt), 12); tick();

        // Reset in the middle of a step
        step_req = 1'b1; mem_busy = 1'b1;
        @(negedge clk); tick();
        step_req = 1'b0;
        @(negedge clk); chk("lit_pre_rst_state", int'(ctrl_state), 3); tick();
        rst_n = 1'b0;
        @(negedge clk); tick();
        @(negedge clk);
        chk("lit_rst_state", int'(ctrl_state), 0);
        chk("lit_rst_vec", int'(dut_vec), int'(V_INIT));
        chk("lit_rst_cycle", int'(cycle_cnt), 0);
        chk("lit_rst_flush", int'(flush_cnt), 0);
        tick();
        rst_n = 1'b1; step_mode = 1'b0; mem_busy = 1'b0;
        for (int k = 0; k < INIT_CYCLES; k++) tick();

        // Counter wrap: 16 advance cycles
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 15) chk("lit_cycle15", int'(cycle_cnt), 15);
            tick();
        end
        @(negedge clk); chk("lit_cycle_wrap", int'(cycle_cnt), 0); tick();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst_n         = ($urandom % 60) != 0;
            if (($urandom % 25) == 0) step_mode = ~step_mode;
            step_req      = ($urandom % 4) == 0;
            mem_busy      = ($urandom % 5) == 0;
            reg_stall     = ($urandom % 3) == 0;
            id_valid      = ($urandom % 4) != 0;
            is_branch_mem = ($urandom % 6) == 0;
            tick();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule : tb_pipeline_ctrl
`default_nettype wire
